// File: rtl/pipe_issue.sv
// pipe_issue: instruction issue unit in front of the operand-read / ALU /
// writeback pipeline. Instructions are buffered in a FIFO and issued one per
// clock through registered out_* fields. A bubble is inserted whenever the
// head instruction reads a register written by one of the last HAZ_WIN
// issue slots.
//
// Optional feature: define PIPE_ISSUE_STALL_CNT_EN to add a 16-bit
// saturating stall_cnt output that counts hazard bubbles.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid && in_ready. in_ready is purely !full and never depends on
// in_valid or on a pop in the same cycle, so a full FIFO refuses the
// push even when the head is being issued on that edge.
module pipe_issue #(
  parameter int DEPTH   = 8,
  parameter int HAZ_WIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_rs1,
  input  logic [3:0]               in_rs2,
  input  logic [3:0]               in_rd,
  input  logic [3:0]               in_func,
  input  logic [7:0]               in_addr,
  input  logic                     issue_en,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [3:0]               out_rs1,
  output logic [3:0]               out_rs2,
  output logic [3:0]               out_rd,
  output logic [3:0]               out_func,
  output logic [7:0]               out_addr,
`ifdef PIPE_ISSUE_STALL_CNT_EN
  output logic [15:0]              stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] func;
    logic [7:0] addr;
  } instr_t;

  instr_t          mem [DEPTH];
  instr_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            fire;
  logic            hazard;

  // Recently issued slots; slot0 always reflects what sits on out_*.
  logic [HAZ_WIN-1:0] win_v;
  logic [3:0]         win_rd [HAZ_WIN];

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;
  assign head     = mem[rd_ptr];
  // Flush wins over both push and issue on the same edge.
  assign push     = in_valid && !full && !flush;
  assign fire     = issue_en && !empty && !hazard && !flush;

  // RAW check: both sources are compared regardless of func.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (win_v[i] && ((win_rd[i] == head.rs1) || (win_rd[i] == head.rs2)))
        hazard = 1'b1;
    end
    if (empty)
      hazard = 1'b0;
  end

  // FIFO storage write; contents need no reset since count gates all reads.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                       func: in_func, addr: in_addr};
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (fire)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !fire)
        cnt <= cnt + 1'b1;
      else if (fire && !push)
        cnt <= cnt - 1'b1;
    end
  end

  // Hazard window shifts only on edges where the pipeline advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_v <= '0;
      for (int i = 0; i < HAZ_WIN; i++)
        win_rd[i] <= '0;
    end else if (flush) begin
      win_v <= '0;
    end else if (issue_en) begin
      for (int i = 1; i < HAZ_WIN; i++) begin
        win_v[i]  <= win_v[i-1];
        win_rd[i] <= win_rd[i-1];
      end
      win_v[0]  <= fire;
      win_rd[0] <= head.rd;
    end
  end

  // Registered issue outputs; fields hold across bubbles and freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_func  <= '0;
      out_addr  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue_en) begin
      out_valid <= fire;
      if (fire) begin
        out_rs1  <= head.rs1;
        out_rs2  <= head.rs2;
        out_rd   <= head.rd;
        out_func <= head.func;
        out_addr <= head.addr;
      end
    end
  end

`ifdef PIPE_ISSUE_STALL_CNT_EN
  // Saturating count of bubbles caused by a hazard on a non-empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (flush)
      stall_cnt <= '0;
    else if (issue_en && hazard && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/pipe_issue.md
Name: pipe_issue

Overview:
- Instruction issue unit that sits in front of the 3-stage register/ALU/memory pipeline (operand read, ALU, writeback to regbank and mem).
- Accepts instructions {rs1, rs2, rd, func, addr} over a valid/ready push interface and buffers them in a FIFO.
- Issues at most one instruction per clock, with registered outputs that drive the pipeline's instruction fields.
- Inserts bubbles when a read-after-write hazard exists against instructions still in flight.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- HAZ_WIN, 2, number of most recently issued slots checked for RAW hazards (1..4).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers an instruction.
- in_ready  output  1  FIFO can accept; equals !full.
- in_rs1  input  4  source register 1.
- in_rs2  input  4  source register 2.
- in_rd  input  4  destination register.
- in_func  input  4  ALU function code, passed through unchanged.
- in_addr  input  8  memory write address, passed through unchanged.
- issue_en  input  1  pipeline permits issue this cycle; 0 freezes issue.
- flush  input  1  synchronous clear of FIFO and hazard window.
- out_valid  output  1  out_* fields hold a real instruction (0 = bubble).
- out_rs1  output  4  issued instruction field (registered).
- out_rs2  output  4  issued instruction field (registered).
- out_rd  output  4  issued instruction field (registered).
- out_func  output  4  issued instruction field (registered).
- out_addr  output  8  issued instruction field (registered).
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, all out_* fields=0, count=0, in_ready=1, hazard window cleared (all slots invalid).
- Push: when in_valid && in_ready at a rising edge, the instruction is written at the tail.
  - in_ready is strictly !full. When full, a push is refused even if a pop occurs in the same cycle.
- Hazard window: shift register of HAZ_WIN slots, each holding {v, rd}.
  - Slot0 always mirrors the current outputs.
  - Every edge on which issue_en=1, the window shifts: slot0 <- {fire, head.rd}.
  - When issue_en=0, the window holds.
- Hazard condition: the FIFO is non-empty and head.rs1 or head.rs2 equals the rd of any valid slot.
  - Every instruction is treated as reading both rs1 and rs2, regardless of func.
- Fire: issue_en && !empty && !hazard.
  - On fire, the head is popped and copied into out_*, and out_valid=1 at the next edge.
- Bubble: issue_en && !fire.
  - out_valid=0 at the next edge; out_* fields hold their previous values.
- Freeze: when issue_en=0, out_valid and out_* hold their values.
- Latency: an instruction pushed into an empty FIFO with no hazard appears on out_* one edge after acceptance.
- Dependent back-to-back pair with HAZ_WIN=2: exactly 2 bubbles are inserted between the two instructions.
- count: increments on push only, decrements on pop only, unchanged when push and pop coincide.
  - Pointers wrap modulo DEPTH.
- Flush (synchronous, priority over push and issue): count=0, pointers=0, all window slots invalidated, out_valid=0 at the next edge.
- Mid-operation reset: identical to the reset values above; no instruction survives.

Optional Feature:
- Macro: PIPE_ISSUE_STALL_CNT_EN.
- When defined: adds output stall_cnt (16 bits), reset to 0 and cleared by flush.
  - Increments on every bubble edge that was caused by a hazard with a non-empty FIFO.
  - Saturates at 16'hFFFF.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then push {rs1=3, rs2=5, rd=10, func=0, addr=125} with issue_en=1 -> out_valid=1 with those fields one edge after acceptance; count returns to 0.
- Push I0 {3,5,rd=10} then I1 {rs1=10, rs2=8, rd=12, func=2, addr=126} back-to-back -> I0 issues, then out_valid=0 for exactly 2 cycles, then I1 issues; stall_cnt=2 when the macro is defined.
- Push 9 independent instructions with issue_en=0 -> in_ready falls after 8 accepted, count=8, the 9th is not accepted; raise issue_en -> 8 issue in order on consecutive cycles, and addr values come out in push order across the pointer wrap.
- FIFO full, in_valid=1 and a pop in the same cycle -> push refused, count=7.
- Load 4 entries, assert flush for one cycle -> count=0, in_ready=1, out_valid=0; a subsequent instruction with rs1 equal to a flushed rd issues with no bubble.
- Assert rst asynchronously mid-stream with out_valid=1 and count=5 -> out_valid=0, count=0, out_* fields=0 before the next clock edge.
